rr_grant_arbiter: RTL and testbench



---
 rtl/rr_grant_arbiter.sv | 68 ++++++
 tb/tb_rr_grant_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: 4-way round-robin arbiter with a MAX_HOLD ownership limit
// and a mandatory idle cycle between grants.
module rr_grant_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] grant_id,
   output logic       grant_valid,
   output logic       preempt
);
   localparam int CW = $clog2(MAX_HOLD + 1);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_n;
   logic [1:0] last_id, last_n, id_n, win;
   logic [CW-1:0] hold_cnt, cnt_n;
   logic pre_n, rel;
   // lowest offset from last_id wins; offset 4 wraps back onto last_id itself
   always_comb begin
      win = last_id;
      for (int i = 4; i >= 1; i--)
         if (req[last_id + 2'(i)]) win = last_id + 2'(i);
   end
   assign rel = !en || !req[grant_id] || hold_cnt == CW'(MAX_HOLD - 1);
   always_comb begin
      state_n = state;
      id_n    = grant_id;
      last_n  = last_id;
      cnt_n   = hold_cnt;
      pre_n   = 1'b0;
      if (state == IDLE) begin
         if (en && |req) begin
            state_n = BUSY;
            id_n    = win;
            cnt_n   = '0;
         end
      end else if (rel) begin
         state_n = IDLE;
         last_n  = grant_id;
         cnt_n   = '0;
         pre_n   = en && req[grant_id];
      end else begin
         cnt_n = hold_cnt + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         grant_id    <= 2'b00;
         last_id     <= 2'b11;
         hold_cnt    <= '0;
         preempt     <= 1'b0;
         grant       <= 4'b0000;
         grant_valid <= 1'b0;
      end else begin
         state       <= state_n;
         grant_id    <= id_n;
         last_id     <= last_n;
         hold_cnt    <= cnt_n;
         preempt     <= pre_n;
         grant       <= state_n == BUSY ? 4'b0001 << id_n : 4'b0000;
         grant_valid <= state_n == BUSY;
      end
   end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed scenarios plus randomized traffic against an
// ownership-level model, on three instances with MAX_HOLD = 2, 4 and 16.
module tb_rr_grant_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] g [3];
   logic [1:0] gi [3];
   logic gv [3];
   logic pr [3];
   int pass = 0;
   int total = 0;
   int mh [3] = '{2, 4, 16};
   int m_own [3];
   int m_held [3];
   int m_last [3];
   bit m_pre [3];

   always #5 clk = ~clk;

   rr_grant_arbiter #(.MAX_HOLD(2)) d2 (.clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .grant(g[0]), .grant_id(gi[0]), .grant_valid(gv[0]), .preempt(pr[0]));
   rr_grant_arbiter #(.MAX_HOLD(4)) d4 (.clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .grant(g[1]), .grant_id(gi[1]), .grant_valid(gv[1]), .preempt(pr[1]));
   rr_grant_arbiter #(.MAX_HOLD(16)) d16 (.clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .grant(g[2]), .grant_id(gi[2]), .grant_valid(gv[2]), .preempt(pr[2]));

   function automatic int pick(int last, logic [3:0] r);
      for (int o = 1; o <= 4; o++)
         if (r[(last + o) % 4]) return (last + o) % 4;
      return -1;
   endfunction

   // owner = -1 means free; m_held counts cycles of the current ownership
   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            m_own[k] = -1; m_held[k] = 0; m_last[k] = 3; m_pre[k] = 0;
         end else begin
            m_pre[k] = 0;
            if (m_own[k] < 0) begin
               if (en && req != 0) begin
                  m_own[k] = pick(m_last[k], req);
                  m_held[k] = 1;
               end
            end else if (!en || !req[m_own[k]]) begin
               m_last[k] = m_own[k]; m_own[k] = -1;
            end else if (m_held[k] == mh[k]) begin
               m_last[k] = m_own[k]; m_own[k] = -1; m_pre[k] = 1;
            end else begin
               m_held[k]++;
            end
         end
      end
   end

   task automatic do_reset;
      rst_n = 1'b0; en = 1'b1; req = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; en = 1'b1; req = 4'b0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (g[k] !== 4'b0000 || gv[k] !== 1'b0 || pr[k] !== 1'b0 || gi[k] !== 2'b00)
               $display("FAIL reset inst%0d cyc%0d: grant=%b valid=%b preempt=%b id=%0d, want 0000/0/0/0",
                        k, c, g[k], gv[k], pr[k], gi[k]);
            else pass++;
         end
      end
   endtask

   task automatic test_single;
      do_reset();
      req = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (g[2] !== 4'b0100 || gi[2] !== 2'd2 || gv[2] !== 1'b1 || pr[2] !== 1'b0)
            $display("FAIL single cyc%0d: grant=%b id=%0d valid=%b preempt=%b, want 0100/2/1/0",
                     c, g[2], gi[2], gv[2], pr[2]);
         else pass++;
      end
      req = 4'b0000;
      @(negedge clk);
      total++;
      if (g[2] !== 4'b0000 || gv[2] !== 1'b0 || pr[2] !== 1'b0)
         $display("FAIL single_release: grant=%b valid=%b preempt=%b, want 0000/0/0", g[2], gv[2], pr[2]);
      else pass++;
   endtask

   task automatic test_rotation;
      logic [3:0] seq [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                               4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         total++;
         if (g[0] !== seq[i] || pr[0] !== (seq[i] == 4'b0000) || gv[0] !== (seq[i] != 4'b0000))
            $display("FAIL rotation step%0d: grant=%b preempt=%b valid=%b, want grant=%b preempt=%b",
                     i, g[0], pr[0], gv[0], seq[i], seq[i] == 4'b0000);
         else pass++;
      end
   endtask

   task automatic test_wrap;
      logic [3:0] seq [5] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
      do_reset();
      req = 4'b1000;
      @(negedge clk);
      total++;
      if (g[0] !== 4'b1000) $display("FAIL wrap_owner3: grant=%b, want 1000", g[0]);
      else pass++;
      req = 4'b0011;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (g[0] !== seq[i]) $display("FAIL wrap step%0d: grant=%b, want %b", i, g[0], seq[i]);
         else pass++;
      end
   endtask

   task automatic test_tie;
      do_reset();
      req = 4'b0010;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 3) req = 4'b0000;
         total++;
         if (g[1] !== 4'b0010 || pr[1] !== 1'b0)
            $display("FAIL tie_hold cyc%0d: grant=%b preempt=%b, want 0010/0", c, g[1], pr[1]);
         else pass++;
      end
      @(negedge clk);
      total++;
      if (g[1] !== 4'b0000 || pr[1] !== 1'b0)
         $display("FAIL tie_release: grant=%b preempt=%b, want 0000/0", g[1], pr[1]);
      else pass++;
      req = 4'b0010;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (g[1] !== 4'b0010 || pr[1] !== 1'b0)
            $display("FAIL timeout_hold cyc%0d: grant=%b preempt=%b, want 0010/0", c, g[1], pr[1]);
         else pass++;
      end
      @(negedge clk);
      total++;
      if (g[1] !== 4'b0000 || pr[1] !== 1'b1 || gv[1] !== 1'b0)
         $display("FAIL timeout_preempt: grant=%b preempt=%b valid=%b, want 0000/1/0", g[1], pr[1], gv[1]);
      else pass++;
      @(negedge clk);
      total++;
      if (g[1] !== 4'b0010 || pr[1] !== 1'b0)
         $display("FAIL timeout_regrant: grant=%b preempt=%b, want 0010/0", g[1], pr[1]);
      else pass++;
      req = 4'b0000;
   endtask

   task automatic test_async;
      do_reset();
      req = 4'b1000;
      @(negedge clk);
      total++;
      if (g[2] !== 4'b1000) $display("FAIL async_setup: grant=%b, want 1000", g[2]);
      else pass++;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (g[2] !== 4'b0000 || gv[2] !== 1'b0 || g[0] !== 4'b0000 || g[1] !== 4'b0000)
         $display("FAIL async_clear: grant=%b/%b/%b valid=%b, want 0000 and 0", g[0], g[1], g[2], gv[2]);
      else pass++;
      #1 rst_n = 1'b1;
      req = 4'b1111;
      @(negedge clk);
      total++;
      if (g[2] !== 4'b0001) $display("FAIL async_priority: grant=%b, want 0001", g[2]);
      else pass++;
   endtask

   task automatic test_enable;
      do_reset();
      req = 4'b1111;
      @(negedge clk);
      total++;
      if (g[2] !== 4'b0001) $display("FAIL enable_setup: grant=%b, want 0001", g[2]);
      else pass++;
      en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (g[2] !== 4'b0000 || pr[2] !== 1'b0 || gv[2] !== 1'b0)
            $display("FAIL enable_off cyc%0d: grant=%b preempt=%b valid=%b, want 0000/0/0", c, g[2], pr[2], gv[2]);
         else pass++;
      end
      en = 1'b1;
      @(negedge clk);
      total++;
      if (g[2] !== 4'b0010) $display("FAIL enable_resume: grant=%b, want 0010", g[2]);
      else pass++;
   endtask

   task automatic test_random;
      logic [3:0] eg;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            eg = (m_own[k] < 0) ? 4'b0000 : 4'(1 << m_own[k]);
            total++;
            if (g[k] !== eg || gv[k] !== (eg != 4'b0000) || pr[k] !== m_pre[k] ||
                (eg != 4'b0000 && gi[k] !== 2'(m_own[k])))
               $display("FAIL random inst%0d cyc%0d: grant=%b id=%0d valid=%b preempt=%b, want grant=%b preempt=%b",
                        k, c, g[k], gi[k], gv[k], pr[k], eg, m_pre[k]);
            else pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_tie();
      test_async();
      test_enable();
      test_random();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
